// File: rtl/ahb_arb_pkg.sv
// Shared constants, types and helpers for the AHB-Lite arbiter.
package ahb_arb_pkg;

    typedef logic [1:0] htrans_t;

    localparam htrans_t HTRANS_IDLE   = 2'b00;
    localparam htrans_t HTRANS_BUSY   = 2'b01;
    localparam htrans_t HTRANS_NONSEQ = 2'b10;
    localparam htrans_t HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Width of a master index; never narrower than one bit.
    function automatic int master_idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set bit of req scanning cyclically from ptr+1,
// with ptr itself considered last.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic found;

    // Scan the request vector starting just after the current pointer.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                idx   = IW'((int'(ptr) + k) % N);
                found = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/ahb_lite_arbiter.sv
// Round-robin AHB-Lite arbiter sharing one slave port between several masters,
// with HLOCK support and a beat budget that forces handover when others wait.
module ahb_lite_arbiter
    import ahb_arb_pkg::*;
#(
    parameter  int NUM_MASTERS    = 2,
    parameter  int DEFAULT_MASTER = 0,
    parameter  int MAX_BEATS      = 16,
    localparam int IW             = master_idx_width(NUM_MASTERS)
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [NUM_MASTERS-1:0]    HBUSREQ,
    input  logic [NUM_MASTERS-1:0]    HLOCK,
    output logic [NUM_MASTERS-1:0]    HGRANT,
    output logic [IW-1:0]             HMASTER,
    input  logic [NUM_MASTERS*32-1:0] M_HADDR,
    input  logic [NUM_MASTERS*2-1:0]  M_HTRANS,
    input  logic [NUM_MASTERS-1:0]    M_HWRITE,
    input  logic [NUM_MASTERS*3-1:0]  M_HSIZE,
    input  logic [NUM_MASTERS*32-1:0] M_HWDATA,
    input  logic [NUM_MASTERS*4-1:0]  M_WSTRB,
    output logic                      S_HSEL,
    output logic [31:0]               S_HADDR,
    output logic [1:0]                S_HTRANS,
    output logic                      S_HWRITE,
    output logic [2:0]                S_HSIZE,
    output logic [31:0]               S_HWDATA,
    output logic [3:0]                S_WSTRB,
    input  logic                      S_HREADYOUT,
    input  logic [1:0]                S_HRESP,
    input  logic [31:0]               S_HRDATA,
    output logic                      HREADY,
    output logic [1:0]                HRESP,
    output logic [31:0]               HRDATA
);

    localparam int BW = $clog2(MAX_BEATS + 1);

    logic [IW-1:0] dmaster;
    logic [BW-1:0] beat_cnt;
    htrans_t       owner_trans;
    logic          owner_active;
    logic          others_req;
    logic          cap_hit;
    logic          rearb;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [IW-1:0] next_owner;

    rr_pick #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_rr_pick (
        .req (HBUSREQ),
        .ptr (HMASTER),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Handover decision for the current address-phase owner.
    always_comb begin
        owner_trans  = htrans_t'(M_HTRANS[2*int'(HMASTER) +: 2]);
        owner_active = (owner_trans == HTRANS_NONSEQ) || (owner_trans == HTRANS_SEQ);
        others_req   = |(HBUSREQ & ~HGRANT);
        // The budget includes the beat accepted on this edge, so an owner gets
        // exactly MAX_BEATS beats before yielding to a waiting master.
        cap_hit      = (beat_cnt == BW'(MAX_BEATS)) ||
                       (owner_active && (beat_cnt == BW'(MAX_BEATS - 1)));
        rearb        = !HLOCK[HMASTER] &&
                       (!HBUSREQ[HMASTER] || (owner_trans == HTRANS_IDLE) ||
                        (cap_hit && others_req));
        next_owner   = pick_any ? pick_idx : IW'(DEFAULT_MASTER);
    end

    // Grant, owner and beat-count registers; everything holds during wait states.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            HGRANT   <= NUM_MASTERS'(1) << DEFAULT_MASTER;
            HMASTER  <= IW'(DEFAULT_MASTER);
            dmaster  <= IW'(DEFAULT_MASTER);
            beat_cnt <= '0;
        end else if (HREADY) begin
            dmaster <= HMASTER;
            if (rearb) begin
                HMASTER  <= next_owner;
                HGRANT   <= NUM_MASTERS'(1) << next_owner;
                beat_cnt <= '0;
            end else if (owner_active && (beat_cnt != BW'(MAX_BEATS))) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Address phase follows HMASTER, write data follows the data-phase owner.
    always_comb begin
        S_HSEL   = 1'b1;
        S_HADDR  = M_HADDR[32*int'(HMASTER) +: 32];
        S_HTRANS = M_HTRANS[2*int'(HMASTER) +: 2];
        S_HWRITE = M_HWRITE[HMASTER];
        S_HSIZE  = M_HSIZE[3*int'(HMASTER) +: 3];
        S_HWDATA = M_HWDATA[32*int'(dmaster) +: 32];
        S_WSTRB  = M_WSTRB[4*int'(dmaster) +: 4];
        HREADY   = S_HREADYOUT;
        HRESP    = S_HRESP;
        HRDATA   = S_HRDATA;
    end

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// Directed self-checking bench for ahb_lite_arbiter (2 masters, MAX_BEATS = 4).
module tb_ahb_lite_arbiter;
    import ahb_arb_pkg::*;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [1:0]  hbusreq, hlock, hgrant;
    logic        hmaster;
    logic [63:0] m_haddr, m_hwdata;
    logic [3:0]  m_htrans;
    logic [1:0]  m_hwrite;
    logic [5:0]  m_hsize;
    logic [7:0]  m_wstrb;
    logic        s_hsel, s_hwrite;
    logic [31:0] s_haddr, s_hwdata, s_hrdata, hrdata;
    logic [1:0]  s_htrans, s_hresp, hresp;
    logic [2:0]  s_hsize;
    logic [3:0]  s_wstrb;
    logic        s_hreadyout, hready;

    logic        use_ovr;
    logic [31:0] ovr_data;
    logic [1:0]  prev_gnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 hclk = ~hclk;

    ahb_lite_arbiter #(
        .NUM_MASTERS    (2),
        .DEFAULT_MASTER (0),
        .MAX_BEATS      (4)
    ) dut (
        .HCLK        (hclk),
        .HRESET      (hreset),
        .HBUSREQ     (hbusreq),
        .HLOCK       (hlock),
        .HGRANT      (hgrant),
        .HMASTER     (hmaster),
        .M_HADDR     (m_haddr),
        .M_HTRANS    (m_htrans),
        .M_HWRITE    (m_hwrite),
        .M_HSIZE     (m_hsize),
        .M_HWDATA    (m_hwdata),
        .M_WSTRB     (m_wstrb),
        .S_HSEL      (s_hsel),
        .S_HADDR     (s_haddr),
        .S_HTRANS    (s_htrans),
        .S_HWRITE    (s_hwrite),
        .S_HSIZE     (s_hsize),
        .S_HWDATA    (s_hwdata),
        .S_WSTRB     (s_wstrb),
        .S_HREADYOUT (s_hreadyout),
        .S_HRESP     (s_hresp),
        .S_HRDATA    (s_hrdata),
        .HREADY      (hready),
        .HRESP       (hresp),
        .HRDATA      (hrdata)
    );

    // Tiny zero-wait memory slave, 16 words.
    logic [31:0] mem [0:15];
    logic        ph_valid, ph_write;
    logic [3:0]  ph_idx;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        ph_valid = 1'b0;
        ph_write = 1'b0;
        ph_idx   = '0;
    end

    always @(posedge hclk) begin
        if (hreset) begin
            ph_valid <= 1'b0;
        end else if (hready) begin
            if (ph_valid && ph_write) begin
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) mem[ph_idx][8*b +: 8] <= s_hwdata[8*b +: 8];
            end
            ph_valid <= s_htrans[1];
            ph_write <= s_hwrite;
            ph_idx   <= s_haddr[5:2];
        end
    end

    assign s_hrdata = use_ovr ? ovr_data : mem[ph_idx];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic apply_reset();
        hreset      = 1'b1;
        hbusreq     = '0;
        hlock       = '0;
        m_haddr     = '0;
        m_hwdata    = '0;
        m_htrans    = '0;
        m_hwrite    = '0;
        m_hsize     = {3'd2, 3'd2};
        m_wstrb     = 8'hFF;
        s_hreadyout = 1'b1;
        s_hresp     = HRESP_OKAY;
        use_ovr     = 1'b0;
        ovr_data    = '0;
        prev_gnt    = '0;
        tick();
        tick();
        hreset = 1'b0;
    endtask

    // Granted masters issue NONSEQ on their first granted cycle, then SEQ; others IDLE.
    task automatic update_drive();
        for (int i = 0; i < 2; i++) begin
            if (hgrant[i]) m_htrans[2*i +: 2] = prev_gnt[i] ? HTRANS_SEQ : HTRANS_NONSEQ;
            else           m_htrans[2*i +: 2] = HTRANS_IDLE;
        end
        prev_gnt = hgrant;
    endtask

    logic burst_exp [0:8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        // Reset state and passthroughs.
        apply_reset();
        check_val("rst_hgrant", hgrant, 2'b01);
        check_val("rst_hmaster", hmaster, 1'b0);
        check_val("hsel_tied", s_hsel, 1'b1);
        use_ovr  = 1'b1;
        ovr_data = 32'h1234_5678;
        #1;
        check_val("hrdata_pass_a", hrdata, 32'h1234_5678);
        ovr_data = 32'hCAFE_F00D;
        s_hresp  = HRESP_ERROR;
        s_hreadyout = 1'b0;
        #1;
        check_val("hrdata_pass_b", hrdata, 32'hCAFE_F00D);
        check_val("hresp_pass", hresp, HRESP_ERROR);
        check_val("hready_pass", hready, 1'b0);
        use_ovr = 1'b0;
        s_hresp = HRESP_OKAY;
        s_hreadyout = 1'b1;

        // M1 alone: grant moves one edge later, then write and read back.
        apply_reset();
        hbusreq = 2'b10;
        m_haddr = {32'h0000_0010, 32'h0000_0020};
        tick();
        check_val("m1_hgrant", hgrant, 2'b10);
        check_val("m1_hmaster", hmaster, 1'b1);
        m_htrans = {HTRANS_NONSEQ, HTRANS_IDLE};
        m_hwrite = 2'b10;
        #1;
        check_val("m1_haddr", s_haddr, 32'h10);
        check_val("m1_hwrite", s_hwrite, 1'b1);
        tick();
        m_hwdata = {32'hDEAD_BEEF, 32'h5555_5555};
        m_wstrb  = {4'hF, 4'h0};
        m_hwrite = 2'b00;
        #1;
        check_val("m1_hwdata", s_hwdata, 32'hDEAD_BEEF);
        tick();
        m_htrans = '0;
        #1;
        check_val("m1_readback", hrdata, 32'hDEAD_BEEF);
        check_val("m1_keeps_grant", hgrant, 2'b10);

        // Both request, MAX_BEATS = 4: owners alternate every 4 accepted beats.
        apply_reset();
        hbusreq = 2'b11;
        for (int k = 0; k < 9; k++) begin
            update_drive();
            check_val($sformatf("burst_owner_%0d", k), hmaster, burst_exp[k]);
            tick();
        end

        // M0 locked for 10 beats while M1 waits.
        apply_reset();
        hbusreq = 2'b11;
        hlock   = 2'b01;
        for (int k = 0; k < 10; k++) begin
            update_drive();
            check_val($sformatf("lock_hgrant_%0d", k), hgrant, 2'b01);
            tick();
        end
        check_val("lock_hgrant_end", hgrant, 2'b01);
        hlock = 2'b00;
        update_drive();
        tick();
        check_val("unlock_hgrant", hgrant, 2'b10);

        // Wait states during an M0 -> M1 handover freeze all arbiter state.
        apply_reset();
        hbusreq  = 2'b11;
        m_hwdata = {32'hBBBB_0000, 32'hAAAA_0000};
        for (int k = 0; k < 3; k++) begin
            update_drive();
            tick();
        end
        update_drive();
        s_hreadyout = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val($sformatf("stall_hgrant_%0d", k), hgrant, 2'b01);
            check_val($sformatf("stall_hmaster_%0d", k), hmaster, 1'b0);
            check_val($sformatf("stall_hwdata_%0d", k), s_hwdata, 32'hAAAA_0000);
        end
        s_hreadyout = 1'b1;
        tick();
        check_val("handover_hgrant", hgrant, 2'b10);
        check_val("handover_hmaster", hmaster, 1'b1);
        check_val("handover_hwdata_m0", s_hwdata, 32'hAAAA_0000);
        update_drive();
        tick();
        check_val("handover_hwdata_m1", s_hwdata, 32'hBBBB_0000);

        // Reset during M1's data phase.
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
        check_val("midrst_hgrant", hgrant, 2'b01);
        check_val("midrst_hmaster", hmaster, 1'b0);
        check_val("midrst_dmaster", dut.dmaster, 1'b0);
        check_val("midrst_beat_cnt", dut.beat_cnt, 0);
        check_val("midrst_hwdata", s_hwdata, 32'hAAAA_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
